// File: rtl/twin_fifo.sv
// Dual-issue op queue: 0-2 pushes and 0-2 in-order pops per cycle, two oldest entries exposed.
// Latency: one falling edge from push to head visibility, no bypass.
// Backpressure: in_ready only while two free slots remain; a pop never frees space in the same cycle.
module twin_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [1:0]                   in_valid,
    input  logic [WIDTH-1:0]             in_data [2],
    output logic                         in_ready,
    output logic [1:0]                   out_valid,
    output logic [WIDTH-1:0]             out_data [2],
    input  logic [1:0]                   can_proceed,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW-1:0]    wr_ptr_next;
    logic [CW-1:0]    count_q;
    logic [1:0]       npush;
    logic [1:0]       npop;
    logic             clear;

    assign clear       = reset | flush;
    assign rd_ptr_next = rd_ptr + AW'(1);
    assign wr_ptr_next = wr_ptr + AW'(1);

    // Readiness looks only at registered occupancy so the producer never depends on consumer timing.
    assign in_ready     = (count_q <= CW'(DEPTH - 2));
    assign out_valid[0] = (count_q != '0);
    assign out_valid[1] = (count_q >= CW'(2));
    assign count        = count_q;

    always_comb begin
        out_data[0] = mem[rd_ptr];
        out_data[1] = mem[rd_ptr_next];
    end

    always_comb begin
        npush = 2'd0;
        if (in_ready) begin
            npush = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
        end
    end

    // Slot 1 may only retire alongside slot 0, and never past what is actually held.
    always_comb begin
        npop = 2'd0;
        if (can_proceed[0] && out_valid[0]) begin
            npop = (can_proceed[1] && out_valid[1]) ? 2'd2 : 2'd1;
        end
    end

    always_ff @(negedge clk) begin
        if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + AW'(npop);
            wr_ptr  <= wr_ptr + AW'(npush);
            count_q <= count_q + CW'(npush) - CW'(npop);
        end
    end

    // Storage is never cleared; a lone slot-1 entry is compacted down to wr_ptr.
    always_ff @(negedge clk) begin
        if (!clear && in_ready) begin
            if (in_valid[0]) begin
                mem[wr_ptr] <= in_data[0];
            end
            if (in_valid[1]) begin
                mem[in_valid[0] ? wr_ptr_next : wr_ptr] <= in_data[1];
            end
        end
    end

endmodule
